keyboard_keys: RTL

Parametrised PS/2 scan-code-set-2 key tracker that replaces the single-key, level-only keyboard decoder. It consumes the byte stream from the PS/2 receiver and tracks make/break state, including E0-extended codes, for NUM_KEYS configurable keys simultaneously. It emits per-key held levels plus one-cycle press and release pulses for the game controller, so jump, duck and restart can overlap and edges are not lost.

---
 rtl/keyboard_keys.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/keyboard_keys.sv
// PS/2 scan-code-set-2 key tracker: decodes make/break (including E0-extended)
// sequences for NUM_KEYS configured keys and emits held levels plus edge pulses.
module keyboard_keys #(
  parameter int                      NUM_KEYS       = 3,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h172, 9'h029, 9'h02D},
  parameter int                      TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                proto_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [NUM_KEYS-1:0] r_held, r_press, r_release;
  logic                r_err;

  logic [NUM_KEYS-1:0] w_hit, w_held_nxt, w_press_nxt, w_release_nxt;
  logic                w_is_e0, w_is_f0, w_is_flush;
  logic                w_make, w_brk, w_ext, w_flush, w_err, w_timeout;

  assign w_is_e0    = (rx_data == 8'hE0);
  assign w_is_f0    = (rx_data == 8'hF0);
  assign w_is_flush = (rx_data == 8'hAA) || (rx_data == 8'hFC) ||
                      (rx_data == 8'h00) || (rx_data == 8'hFF);

  // A byte in the same cycle as the expiry wins, so the timeout needs !rx_valid.
  assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    w_flush     = 1'b0;
    w_err       = 1'b0;
    if (rx_valid) begin
      if (w_is_flush) begin
        w_state_nxt = S_IDLE;
        w_flush     = 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_is_e0)      w_state_nxt = S_EXT;
            else if (w_is_f0) w_state_nxt = S_BRK;
            else              w_make      = 1'b1;
          end
          S_EXT: begin
            if (w_is_f0) w_state_nxt = S_EXT_BRK;
            else if (!w_is_e0) begin
              w_make      = 1'b1;
              w_ext       = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_BRK: begin
            if (w_is_e0) begin
              w_state_nxt = S_EXT;
              w_err       = 1'b1;
            end else if (!w_is_f0) begin
              w_brk       = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            w_state_nxt = S_IDLE;
            if (w_is_e0 || w_is_f0) w_err = 1'b1;
            else begin
              w_brk = 1'b1;
              w_ext = 1'b1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (!rx_valid && (r_state != S_IDLE) && !w_timeout) w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Duplicate table entries simply hit together and update identically.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      w_hit[i] = ({w_ext, rx_data} == KEY_CODES[9*i +: 9]);
  end

  always_comb begin
    w_held_nxt    = r_held;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    if (w_flush) begin
      w_release_nxt = r_held;
      w_held_nxt    = '0;
    end else if (w_make) begin
      w_press_nxt = w_hit & ~r_held;
      w_held_nxt  = r_held | w_hit;
    end else if (w_brk) begin
      w_release_nxt = w_hit & r_held;
      w_held_nxt    = r_held & ~w_hit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_held    <= w_held_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_err     <= w_err;
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign proto_err   = r_err;

endmodule
